hb_load_store_unit: RTL
=======================

Name: hb_load_store_unit

Overview:
- Core-side load/store unit sitting directly upstream of the data-RAM port of the system RAM on the high-speed bus.
- Takes one RV32I load/store request from the execute stage and checks alignment and funct3.
- Issues a single byte-addressed read or write on the bus, waits for the finish handshake, then returns the load data truncated and sign/zero-extended per funct3.
- The RAM returns read data right-aligned (the addressed byte/halfword/word in the low bits, upper bits possibly stale). This block performs all truncation and extension.

Parameters:
- TIMEOUT_CYCLES, 16, bus wait limit in cycles; used only when HB_LSU_TIMEOUT_EN is defined; minimum 2.

Ports:
- hb_clk  input  1  system clock; all logic on rising edge
- hb_rst  input  1  synchronous, active-high reset
- req  input  1  request strobe; sampled only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; misaligned or illegal request, or timeout
- rdata  output  32  load result; valid with done, held until next done
- bus_raddr  output  32  read byte address to data RAM
- bus_waddr  output  32  write byte address
- bus_wdata  output  32  write data, passed right-aligned
- bus_write_width  output  2  00 byte, 01 half, 10 word
- bus_ren  output  1  read enable
- bus_wen  output  1  write enable
- bus_rdata  input  32  RAM read data, right-aligned
- bus_read_finish  input  1  read-complete pulse
- bus_write_finish  input  1  write accepted (may be constant 1)

Behaviour:
- Reset values:
  - state IDLE; all outputs 0, including rdata and the bus address/data/width registers.
  - A reset in any state aborts the operation with no done pulse; bus_ren/bus_wen are low from the next edge.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE, req=1:
  - Latch req_we, req_funct3, req_addr, req_wdata.
  - Illegal if any of the following holds; illegal requests go to RESP with err=1 and make no bus access:
    - funct3 is 011, 110 or 111;
    - a store uses funct3 100 or 101;
    - halfword access with addr[0]=1;
    - word access with addr[1:0]!=0.
  - Otherwise a load goes to RD_ISSUE and a store goes to WR_ISSUE.
  - req while busy=1 is ignored; the upstream stage must hold the request and wait.
- RD_ISSUE:
  - bus_ren=1 for exactly this one cycle; bus_raddr = latched address.
  - Next state RD_WAIT. bus_ren is never held high, because the RAM toggles its finish flag.
- RD_WAIT:
  - bus_ren=0.
  - On bus_read_finish=1, capture bus_rdata and extend:
    - B: sign-extend [7:0]
    - BU: zero-extend [7:0]
    - H: sign-extend [15:0]
    - HU: zero-extend [15:0]
    - W: pass through.
  - Register the result into rdata and go to RESP.
- WR_ISSUE:
  - bus_wen=1 with bus_waddr, bus_wdata, bus_write_width stable.
  - Held until a cycle with bus_write_finish=1; that cycle is the final wen cycle, then go to RESP.
  - bus_wdata = latched wdata unmodified; byte-lane replication is done downstream.
- RESP:
  - done=1 for one cycle; err as determined; return to IDLE.
  - On a store or error, rdata keeps its previous value.
- Bus address registers hold their last value when idle; ren/wen low.
- Latency from req to done, with bus_write_finish constantly 1 and read_finish one cycle after ren:
  - load: 4 cycles (req edge, ren, finish, done)
  - store: 3 cycles
  - illegal: 2 cycles.
- A read_finish arriving outside RD_WAIT is ignored.

Optional Feature:
- Macro HB_LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RD_WAIT/WR_ISSUE and increments each cycle there.
  - On reaching TIMEOUT_CYCLES with no finish, deassert ren/wen and go to RESP with err=1; rdata unchanged.
- Not defined: no counter; the unit waits indefinitely for finish.

Test Plan:
- Load, hb_rst=1 then 0, req load LB addr 0x0000_0103, bus_rdata=0x0000_0080 with finish 1 cycle after ren -> bus_raddr=0x103, ren high 1 cycle, done at cycle 4, rdata=0xFFFF_FF80, err=0; repeat with LBU -> 0x0000_0080.
- Load, LH addr 0x202, bus_rdata=0xDEAD_8001 -> rdata=0xFFFF_8001; LHU -> 0x0000_8001; LW addr 0x200, bus_rdata=0x1234_5678 -> 0x1234_5678.
- Store, SB addr 0x11 wdata 0xAABB_CCDD, bus_write_finish=1 -> bus_wen 1 cycle, write_width=00, waddr=0x11, wdata=0xAABB_CCDD, done at cycle 3; SW with finish delayed 3 cycles -> wen held 4 cycles, done one cycle after the final wen cycle.
- Illegal: LH addr 0x1, SW addr 0x2, funct3=011 -> no ren/wen, done+err at cycle 2, rdata unchanged.
- Boundary: req pulsed while busy -> ignored; hb_rst asserted in RD_WAIT -> next cycle all outputs 0, no done; read_finish spurious in IDLE -> no effect.
- Timeout (HB_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16), load with finish never asserted -> done+err exactly 16 cycles after entering RD_WAIT; without the macro, busy stays high.

Source files
------------

// File: rtl/hb_load_store_unit_if.sv
// Interface bundle for hb_load_store_unit: the core-side request/response
// handshake and the data-RAM bus port.
// slave  : the load/store unit's own view (takes requests, drives the bus).
// master : the surrounding environment (execute stage plus data RAM).
interface hb_load_store_unit_if;
  // core-side request
  logic        req;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // core-side response
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  // data-RAM bus
  logic [31:0] bus_raddr;
  logic [31:0] bus_waddr;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_write_width;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_rdata;
  logic        bus_read_finish;
  logic        bus_write_finish;

  modport slave (
    input  req, req_we, req_funct3, req_addr, req_wdata,
    output busy, done, err, rdata,
    output bus_raddr, bus_waddr, bus_wdata, bus_write_width, bus_ren, bus_wen,
    input  bus_rdata, bus_read_finish, bus_write_finish
  );

  modport master (
    output req, req_we, req_funct3, req_addr, req_wdata,
    input  busy, done, err, rdata,
    input  bus_raddr, bus_waddr, bus_wdata, bus_write_width, bus_ren, bus_wen,
    output bus_rdata, bus_read_finish, bus_write_finish
  );
endinterface

// File: rtl/hb_load_store_unit.sv
// RV32I load/store unit in front of the data-RAM port on the high-speed bus.
// Accepts one request in IDLE, rejects illegal funct3 / misaligned accesses
// without touching the bus, performs a single read or write, and returns
// the load result sign/zero-extended from the right-aligned RAM data.
// Optional macro HB_LSU_TIMEOUT_EN: bounds the bus wait to TIMEOUT_CYCLES
// cycles and reports err on expiry; without it the unit waits forever.
module hb_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 hb_clk,
  input  logic                 hb_rst,
  hb_load_store_unit_if.slave  lsu
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("hb_load_store_unit: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  width_q, width_d;
  logic        illegal;
  logic [31:0] ext_data;

`ifdef HB_LSU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Legality of the incoming request (funct3 encoding and alignment).
  always_comb begin
    illegal = 1'b0;
    case (lsu.req_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = lsu.req_addr[0];
      3'b010:  illegal = |lsu.req_addr[1:0];
      3'b100:  illegal = lsu.req_we;
      3'b101:  illegal = lsu.req_we | lsu.req_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Truncate and extend the right-aligned RAM data per the latched funct3.
  always_comb begin
    ext_data = lsu.bus_rdata;
    case (f3_q)
      3'b000:  ext_data = {{24{lsu.bus_rdata[7]}}, lsu.bus_rdata[7:0]};
      3'b100:  ext_data = {24'h0, lsu.bus_rdata[7:0]};
      3'b001:  ext_data = {{16{lsu.bus_rdata[15]}}, lsu.bus_rdata[15:0]};
      3'b101:  ext_data = {16'h0, lsu.bus_rdata[15:0]};
      default: ext_data = lsu.bus_rdata;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    width_d = width_q;
`ifdef HB_LSU_TIMEOUT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (lsu.req) begin
          we_d  = lsu.req_we;
          f3_d  = lsu.req_funct3;
          err_d = illegal;
          if (illegal) begin
            state_d = RESP;
          end else if (lsu.req_we) begin
            waddr_d = lsu.req_addr;
            wdata_d = lsu.req_wdata;
            width_d = lsu.req_funct3[1:0];
            state_d = WR_ISSUE;
          end else begin
            raddr_d = lsu.req_addr;
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lsu.bus_read_finish) begin
          rdata_d = ext_data;
          state_d = RESP;
        end
`ifdef HB_LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WR_ISSUE: begin
        if (lsu.bus_write_finish) begin
          state_d = RESP;
        end
`ifdef HB_LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge hb_clk) begin
    if (hb_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      width_q <= '0;
`ifdef HB_LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
`ifdef HB_LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Strobes decode straight from the state so reset drops them at the next edge.
  always_comb begin
    lsu.busy            = (state_q != IDLE);
    lsu.done            = (state_q == RESP);
    lsu.err             = (state_q == RESP) & err_q;
    lsu.rdata           = rdata_q;
    lsu.bus_ren         = (state_q == RD_ISSUE);
    lsu.bus_wen         = (state_q == WR_ISSUE);
    lsu.bus_raddr       = raddr_q;
    lsu.bus_waddr       = waddr_q;
    lsu.bus_wdata       = wdata_q;
    lsu.bus_write_width = width_q;
  end

  // we_q is kept for debug visibility of the accepted operation type.
  logic unused_we;
  assign unused_we = we_q;

endmodule
